// File: rtl/ex_muldiv_if.sv
// ID/EX bundle into the multiply/divide unit and its result/stall signals back.
`timescale 1ns/1ps
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic [5:0]      ex_aluop;
  logic [XLEN-1:0] ex_reg1;
  logic [XLEN-1:0] ex_reg2;
  logic [4:0]      ex_wd;
  logic            ex_wreg;
  logic            ignore_id;
  logic            flush;
  logic            stall_req;
  logic            md_valid;
  logic [XLEN-1:0] md_wdata;
  logic [4:0]      md_wd;
  logic            md_wreg;

  modport master (
    output ex_aluop, ex_reg1, ex_reg2, ex_wd, ex_wreg, ignore_id, flush,
    input  stall_req, md_valid, md_wdata, md_wd, md_wreg
  );

  modport slave (
    input  ex_aluop, ex_reg1, ex_reg2, ex_wd, ex_wreg, ignore_id, flush,
    output stall_req, md_valid, md_wdata, md_wd, md_wreg
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage (33-cycle shift-add / restoring divide).
// Define MULDIV_EARLY_OUT_EN to finish zero-operand, divide-by-zero and overflow cases in one cycle.
`timescale 1ns/1ps
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  logic [1:0]        r_state;
  logic [5:0]        r_cnt;
  logic [2:0]        r_op;
  logic              r_neg;
  logic              r_div0;
  logic              r_ovf;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_dividend;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN:0]     r_rem;
  logic [4:0]        r_wd;
  logic              r_wreg;
  logic [XLEN-1:0]   r_md_wdata;
  logic [4:0]        r_md_wd;
  logic              r_md_wreg;

  logic              w_start;
  logic [2:0]        w_op;
  logic              w_sa;
  logic              w_sb;
  logic              w_neg;
  logic              w_div0;
  logic              w_ovf;
  logic [XLEN-1:0]   w_amag;
  logic [XLEN-1:0]   w_bmag;
  logic [XLEN:0]     w_msum;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [XLEN+1:0]   w_trial;
  logic [XLEN-1:0]   w_quo_nxt;
  logic [XLEN:0]     w_rem_nxt;
  logic [XLEN-1:0]   w_iter_res;
  logic              w_md_valid;

  // Final value from the unsigned magnitudes: apply the latched sign, pick the half or
  // quotient/remainder, then let the divide-by-zero and overflow cases override.
  function automatic logic [XLEN-1:0] f_result(
    input logic [2:0]        op,
    input logic              neg,
    input logic              div0,
    input logic              ovf,
    input logic [XLEN-1:0]   dividend,
    input logic [2*XLEN-1:0] prod,
    input logic [XLEN-1:0]   quo,
    input logic [XLEN-1:0]   rem
  );
    logic [2*XLEN-1:0] sprod;
    logic [XLEN-1:0]   res;
    sprod = neg ? -prod : prod;
    if (!op[2])
      res = (op[1:0] == 2'b00) ? sprod[XLEN-1:0] : sprod[2*XLEN-1:XLEN];
    else if (div0)
      res = op[1] ? dividend : '1;
    else if (ovf)
      res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    else if (op[1])
      res = neg ? -rem : rem;
    else
      res = neg ? -quo : quo;
    return res;
  endfunction

  assign w_start = (r_state == S_IDLE) && (bus.ex_aluop[5:3] == 3'b100) &&
                   !bus.ignore_id && !bus.flush;
  assign w_op    = bus.ex_aluop[2:0];
  assign w_sa    = ((w_op == OP_MULH) || (w_op == OP_MULHSU) || (w_op == OP_DIV) ||
                    (w_op == OP_REM)) && bus.ex_reg1[XLEN-1];
  assign w_sb    = ((w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM)) &&
                   bus.ex_reg2[XLEN-1];
  assign w_neg   = (w_op == OP_REM) ? w_sa : (w_sa ^ w_sb);
  assign w_amag  = w_sa ? -bus.ex_reg1 : bus.ex_reg1;
  assign w_bmag  = w_sb ? -bus.ex_reg2 : bus.ex_reg2;
  assign w_div0  = w_op[2] && (bus.ex_reg2 == '0);
  assign w_ovf   = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                   (bus.ex_reg1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.ex_reg2 == '1);

`ifdef MULDIV_EARLY_OUT_EN
  logic            w_early;
  logic [XLEN-1:0] w_early_res;
  assign w_early     = (!w_op[2] && ((bus.ex_reg1 == '0) || (bus.ex_reg2 == '0))) ||
                       w_div0 || w_ovf;
  assign w_early_res = f_result(w_op, w_neg, w_div0, w_ovf, bus.ex_reg1, '0, '0, '0);
`endif

  // Multiplier sits in the low half of the accumulator and is consumed LSB first.
  assign w_msum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_a : '0)};
  assign w_acc_nxt = {w_msum, r_acc[XLEN-1:1]};

  // Restoring step: the borrow out of the trial subtraction decides the quotient bit.
  assign w_trial   = {r_rem, r_quo[XLEN-1]} - {2'b00, r_acc[XLEN-1:0]};
  assign w_quo_nxt = {r_quo[XLEN-2:0], !w_trial[XLEN+1]};
  assign w_rem_nxt = w_trial[XLEN+1] ? {r_rem[XLEN-1:0], r_quo[XLEN-1]} : w_trial[XLEN:0];

  assign w_iter_res = f_result(r_op, r_neg, r_div0, r_ovf, r_dividend,
                               w_acc_nxt, w_quo_nxt, w_rem_nxt[XLEN-1:0]);

  assign w_md_valid    = (r_state == S_DONE) && !bus.flush;
  assign bus.md_valid  = w_md_valid;
  assign bus.md_wdata  = r_md_wdata;
  assign bus.md_wd     = r_md_wd;
  assign bus.md_wreg   = r_md_wreg && w_md_valid;
  assign bus.stall_req = w_start || (r_state == S_MUL) || (r_state == S_DIV);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_neg      <= 1'b0;
      r_div0     <= 1'b0;
      r_ovf      <= 1'b0;
      r_a        <= '0;
      r_dividend <= '0;
      r_acc      <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_wd       <= '0;
      r_wreg     <= 1'b0;
      r_md_wdata <= '0;
      r_md_wd    <= '0;
      r_md_wreg  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_op       <= w_op;
            r_neg      <= w_neg;
            r_div0     <= w_div0;
            r_ovf      <= w_ovf;
            r_a        <= w_amag;
            r_dividend <= bus.ex_reg1;
            r_acc      <= {{XLEN{1'b0}}, w_bmag};
            r_quo      <= w_amag;
            r_rem      <= '0;
            r_wd       <= bus.ex_wd;
            r_wreg     <= bus.ex_wreg;
            r_cnt      <= 6'd32;
            r_state    <= w_op[2] ? S_DIV : S_MUL;
`ifdef MULDIV_EARLY_OUT_EN
            if (w_early) begin
              r_state    <= S_DONE;
              r_md_wdata <= w_early_res;
              r_md_wd    <= bus.ex_wd;
              r_md_wreg  <= bus.ex_wreg;
            end
`endif
          end
        end
        S_MUL, S_DIV: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else begin
            if (r_state == S_MUL) begin
              r_acc <= w_acc_nxt;
            end else begin
              r_quo <= w_quo_nxt;
              r_rem <= w_rem_nxt;
            end
            r_cnt <= r_cnt - 6'd1;
            // The last iteration's result is registered straight into the output stage.
            if (r_cnt == 6'd1) begin
              r_state    <= S_DONE;
              r_md_wdata <= w_iter_res;
              r_md_wd    <= r_wd;
              r_md_wreg  <= r_wreg;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M cases plus randomized ops against a
// plain-arithmetic reference model, with a per-cycle compare of stall and result outputs.
`timescale 1ns/1ps
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;

  ex_muldiv_if #(.XLEN(32)) bus();

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  int          checks = 0;
  int          fails = 0;
  logic        checkEn = 1'b0;
  logic        expStall = 1'b0;
  logic        expValid = 1'b0;
  logic        expZero = 1'b0;
  logic        expWreg = 1'b0;
  logic [31:0] expWdata = '0;
  logic [4:0]  expWd = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference result computed directly from the RV32M definitions with wide arithmetic.
  function automatic logic [31:0] refModel(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    longint      q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (op)
      6'h20: begin p = 64'(sa * sb); return p[31:0]; end
      6'h21: begin p = 64'(sa * sb); return p[63:32]; end
      6'h22: begin p = 64'(sa * ub); return p[63:32]; end
      6'h23: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      6'h24: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = sa / sb;
        return q[31:0];
      end
      6'h25: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      6'h26: begin
        if (b == 0) return a;
        q = sa % sb;
        return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic early;
    early = ((op < 6'h24) && (a == 0 || b == 0)) || ((op >= 6'h24) && (b == 0)) ||
            ((op == 6'h24 || op == 6'h26) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (EarlyOut && early) return 1;
    return 33;
  endfunction

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("stall_req", 32'(bus.stall_req), 32'(expStall));
      checkOutput("md_valid", 32'(bus.md_valid), 32'(expValid));
      if (expValid) begin
        checkOutput("md_wdata", bus.md_wdata, expWdata);
        checkOutput("md_wd", 32'(bus.md_wd), 32'(expWd));
        checkOutput("md_wreg", 32'(bus.md_wreg), 32'(expWreg));
      end else begin
        checkOutput("md_wreg_idle", 32'(bus.md_wreg), 32'd0);
      end
      if (expZero) begin
        checkOutput("md_wdata_reset", bus.md_wdata, 32'd0);
        checkOutput("md_wd_reset", 32'(bus.md_wd), 32'd0);
      end
    end
  end

  task automatic setBubble();
    bus.ex_aluop  = 6'h00;
    bus.ignore_id = 1'b1;
    bus.flush     = 1'b0;
    bus.ex_wreg   = 1'b0;
  endtask

  task automatic idleCycles(input int n, input logic [5:0] op, input logic ign, input logic fl);
    repeat (n) begin
      @(posedge clk); #1;
      bus.ex_aluop  = op;
      bus.ignore_id = ign;
      bus.flush     = fl;
      bus.ex_reg1   = $urandom;
      bus.ex_reg2   = $urandom;
      bus.ex_wd     = 5'($urandom);
      bus.ex_wreg   = 1'b1;
      expStall      = 1'b0;
      expValid      = 1'b0;
    end
  endtask

  // Drives one M op held in ID/EX until DONE; abortAt selects an optional flush or reset cycle.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] wd, input logic wreg, input logic [31:0] expRes,
                               input int abortAt, input bit abortRst);
    int lat;
    lat = latency(op, a, b);
    @(posedge clk); #1;
    bus.ex_aluop  = op;
    bus.ex_reg1   = a;
    bus.ex_reg2   = b;
    bus.ex_wd     = wd;
    bus.ex_wreg   = wreg;
    bus.ignore_id = 1'b0;
    bus.flush     = 1'b0;
    expZero  = 1'b0;
    expStall = 1'b1;
    expValid = 1'b0;
    for (int k = 1; k < lat; k++) begin
      @(posedge clk); #1;
      if (k == abortAt) begin
        if (abortRst) rst = 1'b1;
        else bus.flush = 1'b1;
        expStall = 1'b1;
        expValid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        setBubble();
        expStall = 1'b0;
        expValid = 1'b0;
        if (abortRst) expZero = 1'b1;
        return;
      end
    end
    @(posedge clk); #1;
    expStall = 1'b0;
    if (abortAt == lat && !abortRst) begin
      bus.flush = 1'b1;
      expValid  = 1'b0;
    end else begin
      expValid = 1'b1;
      expWdata = expRes;
      expWd    = wd;
      expWreg  = wreg;
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wd;
    logic        wr;
    setBubble();
    bus.ex_reg1 = '0;
    bus.ex_reg2 = '0;
    bus.ex_wd   = '0;

    checkOutput("pin_mul", refModel(6'h20, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    checkOutput("pin_mulh", refModel(6'h21, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0);
    checkOutput("pin_mulhsu", refModel(6'h22, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    checkOutput("pin_div", refModel(6'h24, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    checkOutput("pin_rem", refModel(6'h26, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    checkOutput("pin_ovf", refModel(6'h24, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

    @(posedge clk); #1;
    checkEn = 1'b1;
    expZero = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idleCycles(2, 6'h00, 1'b1, 1'b0);

    applyStimulus(6'h20, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, 32'hFFFF_FFEB, -1, 1'b0);
    applyStimulus(6'h23, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1, 32'hFFFF_FFFE, -1, 1'b0);
    applyStimulus(6'h21, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0, 32'h0, -1, 1'b0);
    applyStimulus(6'h22, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b1, 32'hFFFF_FFFF, -1, 1'b0);
    applyStimulus(6'h24, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1, 32'hFFFF_FFFD, -1, 1'b0);
    applyStimulus(6'h26, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1, 32'hFFFF_FFFF, -1, 1'b0);
    applyStimulus(6'h25, 32'd100, 32'd7, 5'd11, 1'b1, 32'd14, -1, 1'b0);
    applyStimulus(6'h27, 32'd100, 32'd7, 5'd12, 1'b1, 32'd2, -1, 1'b0);
    applyStimulus(6'h25, 32'd5, 32'd0, 5'd13, 1'b1, 32'hFFFF_FFFF, -1, 1'b0);
    applyStimulus(6'h26, 32'd5, 32'd0, 5'd14, 1'b1, 32'd5, -1, 1'b0);
    applyStimulus(6'h24, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1, 32'h8000_0000, -1, 1'b0);
    applyStimulus(6'h26, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b1, 32'h0, -1, 1'b0);

    idleCycles(3, 6'h20, 1'b1, 1'b0);
    idleCycles(3, 6'h01, 1'b0, 1'b0);
    idleCycles(2, 6'h24, 1'b0, 1'b1);

    applyStimulus(6'h24, 32'd1000, 32'd3, 5'd17, 1'b1, 32'd333, 10, 1'b0);
    idleCycles(2, 6'h00, 1'b1, 1'b0);
    applyStimulus(6'h25, 32'd100, 32'd7, 5'd18, 1'b1, 32'd14, 33, 1'b0);
    idleCycles(2, 6'h00, 1'b1, 1'b0);
    applyStimulus(6'h24, 32'd1000, 32'd3, 5'd19, 1'b1, 32'd333, 10, 1'b1);
    idleCycles(2, 6'h00, 1'b1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      op = 6'h20 + 6'($urandom_range(0, 7));
      a  = pickOperand();
      b  = pickOperand();
      wd = 5'($urandom);
      wr = 1'($urandom);
      applyStimulus(op, a, b, wd, wr, refModel(op, a, b), -1, 1'b0);
      if ($urandom_range(0, 1) == 1)
        idleCycles($urandom_range(1, 3), 6'h00, 1'b1, 1'b0);
    end
    idleCycles(2, 6'h00, 1'b1, 1'b0);

    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
